// File: rtl/tdc_result_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between the TDC result channels.
// Each granted result is sent as: HEADER, channel id, data bytes MSB first, XOR checksum.
module tdc_result_arbiter #(
  parameter int         N_CH   = 6,
  parameter int         DATA_W = 24,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_CH-1:0]        ch_valid_i,
  input  logic [N_CH*DATA_W-1:0] ch_data_i,
  output logic [N_CH-1:0]        ch_ready_o,
  input  logic                   pause_i,
  input  logic                   tx_busy_i,
  output logic [7:0]             tx_data_o,
  output logic                   new_tx_data_o,
  output logic                   busy_o,
  output logic [2:0]             grant_ch_o
);

  localparam int NB     = DATA_W / 8;
  localparam int NBYTES = NB + 3;
  localparam int IW     = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GUARD} state_t;

  state_t            state_q, state_d;
  logic [N_CH-1:0]   ready_q, ready_d;
  logic [7:0]        txd_q, txd_d;
  logic [7:0]        chk_q, chk_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic [2:0]        grant_q, grant_d;
  logic [2:0]        last_q, last_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic              pick_found;
  logic [2:0]        pick_ch;
  logic [DATA_W-1:0] sel_word;
  logic [7:0]        cur_byte;
  logic              is_data_byte;

  // Lowest valid index above last_q wins; otherwise wrap to the lowest at or below it.
  always_comb begin
    pick_found = 1'b0;
    pick_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_valid_i[i] && (3'(i) <= last_q)) begin
        pick_found = 1'b1;
        pick_ch    = 3'(i);
      end
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_valid_i[i] && (3'(i) > last_q)) begin
        pick_found = 1'b1;
        pick_ch    = 3'(i);
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q == 3'(i)) sel_word = ch_data_i[i*DATA_W +: DATA_W];
    end
  end

  // word_q is shifted left after each data byte, so its top byte is always the next one.
  always_comb begin
    is_data_byte = (idx_q >= IW'(2)) && (idx_q != LAST_IDX);
    if (idx_q == '0)
      cur_byte = HEADER;
    else if (idx_q == IW'(1))
      cur_byte = {5'b0, grant_q};
    else if (idx_q == LAST_IDX)
      cur_byte = chk_q;
    else
      cur_byte = word_q[DATA_W-1 -: 8];
  end

  always_comb begin
    state_d  = state_q;
    ready_d  = '0;
    txd_d    = txd_q;
    chk_d    = chk_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    grant_d  = grant_q;
    last_d   = last_q;
    word_d   = word_q;
    idx_d    = idx_q;
    case (state_q)
      IDLE: begin
        if (!pause_i && pick_found) begin
          grant_d = pick_ch;
          busy_d  = 1'b1;
          ready_d = {{(N_CH-1){1'b0}}, 1'b1} << pick_ch;
          state_d = GRANT;
        end
      end
      GRANT: begin
        word_d  = sel_word;
        idx_d   = '0;
        chk_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy_i) begin
          strobe_d = 1'b1;
          txd_d    = cur_byte;
          chk_d    = chk_q ^ cur_byte;
          if (is_data_byte) word_d = word_q << 8;
          state_d  = GUARD;
        end
      end
      GUARD: begin
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          last_d  = grant_q;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = SEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ready_q  <= '0;
      txd_q    <= '0;
      chk_q    <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      grant_q  <= '0;
      last_q   <= 3'(N_CH - 1);
      word_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      txd_q    <= txd_d;
      chk_q    <= chk_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
    end
  end

  assign ch_ready_o    = ready_q;
  assign tx_data_o     = txd_q;
  assign new_tx_data_o = strobe_q;
  assign busy_o        = busy_q;
  assign grant_ch_o    = grant_q;

endmodule

// File: tb/tb_tdc_result_arbiter.sv
// Scoreboard bench for tdc_result_arbiter: directed scenarios plus a randomized soak,
// checked against a packet-level round-robin model.
`timescale 1ns/1ps
module tb_tdc_result_arbiter;
  localparam int N_CH   = 6;
  localparam int DATA_W = 24;
  localparam int NB     = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_CH-1:0]        ch_valid = '0;
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [N_CH-1:0]        ch_ready;
  logic                   pause = 1'b0;
  logic                   tx_busy = 1'b0;
  logic [7:0]             tx_data;
  logic                   new_tx_data;
  logic                   busy;
  logic [2:0]             grant_ch;
  logic [DATA_W-1:0]      dat [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_pack
    assign ch_data[g*DATA_W +: DATA_W] = dat[g];
  end

  tdc_result_arbiter #(.N_CH(N_CH), .DATA_W(DATA_W), .HEADER(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst), .ch_valid_i(ch_valid), .ch_data_i(ch_data),
    .ch_ready_o(ch_ready), .pause_i(pause), .tx_busy_i(tx_busy),
    .tx_data_o(tx_data), .new_tx_data_o(new_tx_data), .busy_o(busy),
    .grant_ch_o(grant_ch)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]      exp_q[$];
  logic [7:0]      rx_log[$];
  int              grant_log[$];
  int              model_last = N_CH - 1;
  logic [N_CH-1:0] ack_seen = '0;
  logic [N_CH-1:0] rereq = '0;
  bit              prev_strobe = 1'b0;
  int              last_strobe_cyc = 0;
  int              strobe_cnt = 0;
  bit              gap_en = 1'b0;
  logic [N_CH-1:0] vprev = '0;
  logic            pprev = 1'b0;
  logic            bprev = 1'b0;
  logic [7:0]      mon_exp;
  int              mon_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first requester found scanning last+1, last+2, ... modulo N_CH.
  function automatic int rr_pick(input logic [N_CH-1:0] v, input int last);
    for (int k = 1; k <= N_CH; k++) begin
      if (v[(last + k) % N_CH]) return (last + k) % N_CH;
    end
    return -1;
  endfunction

  task automatic push_packet(input int ch, input logic [DATA_W-1:0] d);
    logic [7:0] x, b;
    x = 8'hA5;
    exp_q.push_back(8'hA5);
    b = 8'(ch);
    x ^= b;
    exp_q.push_back(b);
    for (int i = NB - 1; i >= 0; i--) begin
      b = d[i*8 +: 8];
      x ^= b;
      exp_q.push_back(b);
    end
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    vprev <= ch_valid;
    pprev <= pause;
    bprev <= tx_busy;
  end

  // Monitor: compares every byte strobe and every grant against the model.
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
    end else begin
      if (new_tx_data) begin
        chk("strobe_back_to_back", {31'b0, prev_strobe}, 0);
        chk("strobe_while_tx_busy", {31'b0, bprev}, 0);
        chk("byte_expected", {31'b0, exp_q.size() > 0}, 1);
        if (exp_q.size() > 0) begin
          mon_exp = exp_q.pop_front();
          chk("tx_byte", {24'b0, tx_data}, {24'b0, mon_exp});
        end
        rx_log.push_back(tx_data);
        strobe_cnt++;
        last_strobe_cyc = cyc;
      end
      prev_strobe = new_tx_data;
      if (ch_ready != '0) begin
        mon_g = rr_pick(vprev, model_last);
        chk("ready_onehot", {31'b0, $onehot(ch_ready)}, 1);
        chk("grant_while_paused", {31'b0, pprev}, 0);
        chk("ready_index", 32'(ch_ready), (mon_g < 0) ? 32'h0 : (32'h1 << mon_g));
        chk("grant_ch", {29'b0, grant_ch}, 32'(mon_g));
        chk("busy_at_grant", {31'b0, busy}, 1);
        if (gap_en) begin
          chk("packet_gap_le2", {31'b0, (cyc - last_strobe_cyc - 1) <= 2}, 1);
          gap_en = 1'b0;
        end
        if (mon_g >= 0) begin
          push_packet(mon_g, dat[mon_g]);
          model_last = mon_g;
          grant_log.push_back(mon_g);
        end
        ack_seen |= ch_ready;
      end
    end
  end

  // Inputs change 2ns after the rising edge; acknowledged requesters drop or re-request.
  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < N_CH; i++) begin
      if (ack_seen[i]) begin
        ack_seen[i] = 1'b0;
        if (rereq[i]) dat[i] = DATA_W'($urandom);
        else          ch_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((ch_valid != '0 || exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'b0, n < budget}, 1);
  endtask

  task automatic wait_strobes(input string name, input int k);
    int s0 = strobe_cnt;
    int n = 0;
    while (strobe_cnt < s0 + k && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'b0, n < 200}, 1);
  endtask

  task automatic wait_grants(input string name, input int k);
    int n = 0;
    while (grant_log.size() < k && n < 400) begin
      tick();
      n++;
    end
    chk(name, {31'b0, n < 400}, 1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[7] = '{0, 1, 2, 3, 4, 5, 0};
    logic [7:0] t1_bytes[6] = '{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'hD6};
    int n;
    int s0;
    int g0;

    for (int i = 0; i < N_CH; i++) dat[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({ch_ready, tx_data, new_tx_data, busy, grant_ch}), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    // All channels requesting continuously: strict rotation starting at ch0.
    for (int i = 0; i < N_CH; i++) dat[i] = DATA_W'($urandom);
    grant_log.delete();
    rereq    = '1;
    ch_valid = '1;
    wait_grants("rr_wait", 7);
    rereq = '0;
    if (grant_log.size() >= 7) begin
      for (int k = 0; k < 7; k++) chk("rr_order", 32'(grant_log[k]), 32'(order[k]));
    end
    wait_drain("rr_drain", 600);

    // Single ch3 packet with a known byte sequence.
    rx_log.delete();
    dat[3]      = 24'h123456;
    ch_valid[3] = 1'b1;
    wait_drain("t1_drain", 200);
    chk("t1_len", 32'(rx_log.size()), 6);
    if (rx_log.size() == 6) begin
      for (int k = 0; k < 6; k++) chk("t1_byte", {24'b0, rx_log[k]}, {24'b0, t1_bytes[k]});
    end

    // tx_busy held for 50 cycles mid-packet.
    dat[5]      = DATA_W'($urandom);
    ch_valid[5] = 1'b1;
    wait_strobes("t3_wait", 2);
    tx_busy = 1'b1;
    tick();
    s0 = strobe_cnt;
    repeat (49) tick();
    chk("t3_no_strobe_held", 32'(strobe_cnt), 32'(s0));
    tx_busy = 1'b0;
    wait_drain("t3_drain", 200);

    // pause raised mid-packet: packet completes, no grant until pause falls.
    dat[2]      = DATA_W'($urandom);
    ch_valid[2] = 1'b1;
    wait_strobes("t4_wait", 2);
    pause       = 1'b1;
    dat[4]      = DATA_W'($urandom);
    ch_valid[4] = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    repeat (2) tick();
    chk("t4_busy_low_paused", {31'b0, busy}, 0);
    repeat (20) tick();
    chk("t4_ch4_pending", {31'b0, ch_valid[4]}, 1);
    g0    = grant_log.size();
    pause = 1'b0;
    n = 0;
    while (grant_log.size() == g0 && n < 10) begin tick(); n++; end
    chk("t4_grant_after_unpause", {31'b0, n <= 2}, 1);
    wait_drain("t4_drain", 200);

    // Reset mid-packet, then ch0 and ch4 competing.
    dat[1]      = DATA_W'($urandom);
    ch_valid[1] = 1'b1;
    wait_strobes("t5_wait", 3);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_reset_outputs", 32'({ch_ready, tx_data, new_tx_data, busy, grant_ch}), 0);
    exp_q.delete();
    grant_log.delete();
    model_last = N_CH - 1;
    ack_seen   = '0;
    dat[0]     = DATA_W'($urandom);
    dat[4]     = DATA_W'($urandom);
    ch_valid   = 6'b010001;
    tick();
    tick();
    @(negedge clk) rst = 1'b0;
    wait_grants("t5_wait_grant", 1);
    if (grant_log.size() > 0) chk("t5_first_after_reset", 32'(grant_log[0]), 0);
    wait_drain("t5_drain", 300);

    // ch1 then ch2 back to back: inter-packet gap.
    grant_log.delete();
    dat[1]      = DATA_W'($urandom);
    ch_valid[1] = 1'b1;
    tick();
    dat[2]      = DATA_W'($urandom);
    ch_valid[2] = 1'b1;
    wait_grants("t6_wait", 1);
    gap_en = 1'b1;
    wait_drain("t6_drain", 300);
    chk("t6_gap_checked", {31'b0, gap_en}, 0);

    // Randomized soak.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_valid[i] && $urandom_range(0, 15) == 0) begin
          dat[i]      = DATA_W'($urandom);
          ch_valid[i] = 1'b1;
        end
      end
      tx_busy = ($urandom_range(0, 3) == 0);
      pause   = ($urandom_range(0, 31) == 0);
      tick();
    end
    pause   = 1'b0;
    tx_busy = 1'b0;
    wait_drain("random_drain", 3000);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
